// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with a registered
// output stage. Selection is round-robin (RR_MODE=1) or by SEL (RR_MODE=0).
// Optional transfer counter enabled by defining STREAM_MUX_STATS_EN.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   CNT_CLR         (stats build) synchronous clear of XFER_CNT
//   XFER_CNT        (stats build) 16-bit output handshake counter
//   IN_DATA         flattened channel data, channel i = [i*N +: N]
//   IN_VALID        per-channel valid
//   IN_READY        per-channel ready (combinational)
//   SEL             channel select, fixed mode only
//   OUT_DATA        registered output data
//   OUT_CH          index of the channel that supplied OUT_DATA
//   OUT_VALID       registered output valid
//   OUT_READY       consumer ready
module stream_mux_rr #(
    parameter int unsigned N       = 32,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned RR_MODE = 1,
    parameter int unsigned SEL_W   = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef STREAM_MUX_STATS_EN
    input  logic                CNT_CLR,
    output logic [15:0]         XFER_CNT,
`endif
    input  logic [NUM_CH*N-1:0] IN_DATA,
    input  logic [NUM_CH-1:0]   IN_VALID,
    output logic [NUM_CH-1:0]   IN_READY,
    input  logic [SEL_W-1:0]    SEL,
    output logic [N-1:0]        OUT_DATA,
    output logic [SEL_W-1:0]    OUT_CH,
    output logic                OUT_VALID,
    input  logic                OUT_READY
);

    // Valid vector padded to the full select range so out-of-range SEL reads 0.
    localparam int unsigned SPAN = 1 << SEL_W;

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             can_load;
    logic             xfer;
    logic [SPAN-1:0]  valid_ext;
    logic [N-1:0]     gnt_data;

    assign valid_ext = SPAN'(IN_VALID);

    // Output register can take a beat when empty or draining this cycle.
    assign can_load = !rst && (!OUT_VALID || OUT_READY);
    assign xfer     = can_load && gnt_any;

    // Grant: round-robin search starting after the last winner, or SEL.
    always_comb begin : grant_sel
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (RR_MODE != 0) begin
            for (int unsigned k = 1; k <= NUM_CH; k++) begin
                cand = SEL_W'((32'(ptr) + k) % NUM_CH);
                if (!gnt_any && valid_ext[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end else begin
            gnt_any = valid_ext[SEL];
            gnt_idx = SEL;
        end
    end

    // Data of the granted channel.
    always_comb begin : data_sel
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = IN_DATA[i*N +: N];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ready
        assign IN_READY[g] = xfer && (gnt_idx == SEL_W'(g));
    end

    // Output stage and priority pointer; pointer only moves on a transfer.
    always_ff @(posedge clk) begin : out_reg
        if (rst) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_CH    <= '0;
            ptr       <= SEL_W'(NUM_CH - 1);
        end else if (xfer) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= gnt_data;
            OUT_CH    <= gnt_idx;
            ptr       <= gnt_idx;
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

`ifdef STREAM_MUX_STATS_EN
    // Output handshake counter; clear wins over increment, wraps at 16 bits.
    always_ff @(posedge clk) begin : stats_cnt
        if (rst || CNT_CLR) begin
            XFER_CNT <= '0;
        end else if (OUT_VALID && OUT_READY) begin
            XFER_CNT <= XFER_CNT + 16'd1;
        end
    end
`else
    // Statistics counter not built.
`endif

endmodule
